// File: rtl/stoch_to_bin_if.sv
// Handshake/data bundle for the stochastic-to-binary converter.
// The master side produces the bitstream and acknowledges results; the slave side is the converter.
interface stoch_to_bin_if #(
  parameter int unsigned N = 8
);
  logic         EN;
  logic         CLEAR;
  logic         IN;
  logic         ACK;
  logic [N-1:0] OUT;
  logic         VALID;
  logic         OVR;

  modport master (
    output EN, CLEAR, IN, ACK,
    input  OUT, VALID, OVR
  );

  modport slave (
    input  EN, CLEAR, IN, ACK,
    output OUT, VALID, OVR
  );
endinterface

// File: rtl/stoch_to_bin.sv
// Counts ones of a unipolar stochastic bitstream over windows of 2^N enabled cycles
// and presents the saturated count with a VALID/ACK handshake and a sticky overrun flag.
module stoch_to_bin #(
  parameter int unsigned N = 8
) (
  input logic           CLK,
  input logic           RESET,
  stoch_to_bin_if.slave bus
);

  logic [N:0]   ones_cnt;
  logic [N-1:0] pos_cnt;
  logic [N:0]   ones_next;
  logic         win_done;

  always_comb begin
    ones_next = ones_cnt + (N+1)'(bus.IN);
    win_done  = bus.EN && !bus.CLEAR && (pos_cnt == '1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ones_cnt  <= '0;
      pos_cnt   <= '0;
      bus.OUT   <= '0;
      bus.VALID <= 1'b0;
      bus.OVR   <= 1'b0;
    end else begin
      if (bus.CLEAR || win_done) begin
        ones_cnt <= '0;
        pos_cnt  <= '0;
      end else if (bus.EN) begin
        ones_cnt <= ones_next;
        pos_cnt  <= pos_cnt + N'(1);
      end

      // A completing window wins over ACK; a full-ones window saturates to all ones.
      if (win_done) begin
        bus.OUT   <= ones_next[N] ? '1 : ones_next[N-1:0];
        bus.VALID <= 1'b1;
        if (bus.VALID && !bus.ACK)
          bus.OVR <= 1'b1;
      end else if (bus.ACK && bus.VALID) begin
        bus.VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stoch_to_bin.sv
// Directed bench for stoch_to_bin with N=4 (16-cycle windows).
module tb_stoch_to_bin;
  localparam int unsigned N = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  stoch_to_bin_if #(.N(N)) bus ();

  stoch_to_bin #(.N(N)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic en, input logic in_bit, input logic ack, input logic clr);
    bus.EN    = en;
    bus.IN    = in_bit;
    bus.ACK   = ack;
    bus.CLEAR = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic in_bit);
    for (int i = 0; i < n; i++) drive(1'b1, in_bit, 1'b0, 1'b0);
  endtask

  task automatic outs(input string tag, input int o, input int v, input int ov);
    check({tag, ".OUT"},   int'(bus.OUT),   o);
    check({tag, ".VALID"}, int'(bus.VALID), v);
    check({tag, ".OVR"},   int'(bus.OVR),   ov);
  endtask

  task automatic ack_idle();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.EN = 1'b0; bus.IN = 1'b0; bus.ACK = 1'b0; bus.CLEAR = 1'b0;
    rst = 1'b1;
    #12;
    outs("reset", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // All ones: count 16 saturates to 15
    run(15, 1'b1);
    check("ones15.VALID", int'(bus.VALID), 0);
    run(1, 1'b1);
    outs("ones16", 15, 1, 0);
    ack_idle();
    check("ones_ack.VALID", int'(bus.VALID), 0);
    check("ones_ack.OUT", int'(bus.OUT), 15);

    // Alternating 1,0 -> 8
    for (int i = 0; i < 16; i++) drive(1'b1, (i % 2 == 0), 1'b0, 1'b0);
    outs("alt", 8, 1, 0);
    ack_idle();

    // All zeros -> 0 with VALID
    run(16, 1'b0);
    outs("zeros", 0, 1, 0);
    ack_idle();

    // EN low for 5 edges mid-window: completion only at edge 21
    run(8, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    run(7, 1'b1);
    check("gap20.VALID", int'(bus.VALID), 0);
    run(1, 1'b1);
    outs("gap21", 15, 1, 0);
    ack_idle();

    // Two windows without ACK: 4 then 12 ones -> overrun
    run(4, 1'b1);
    run(12, 1'b0);
    outs("ovr_w1", 4, 1, 0);
    run(12, 1'b1);
    run(4, 1'b0);
    outs("ovr_w2", 12, 1, 1);
    ack_idle();
    outs("ovr_ack", 12, 0, 1);

    // Reset mid-cycle clears the sticky flag
    #3 rst = 1'b1;
    #1;
    check("rst_ovr.OVR", int'(bus.OVR), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ACK coincident with completion: no overrun
    run(5, 1'b1);
    run(11, 1'b0);
    outs("ackc_w1", 5, 1, 0);
    run(10, 1'b1);
    run(5, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    outs("ackc_w2", 10, 1, 0);

    // Async reset at position 7 while a result is pending
    run(7, 1'b1);
    #3 rst = 1'b1;
    #1;
    outs("arst", 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(15, 1'b1);
    check("arst15.VALID", int'(bus.VALID), 0);
    run(1, 1'b1);
    outs("arst16", 15, 1, 0);

    // CLEAR at position 7 (with EN high) keeps outputs, restarts the window
    run(7, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    outs("clr", 15, 1, 0);
    ack_idle();
    check("clr_ack.VALID", int'(bus.VALID), 0);
    run(15, 1'b0);
    check("clr15.VALID", int'(bus.VALID), 0);
    run(1, 1'b0);
    outs("clr16", 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/stoch_to_bin.md
STOCH_TO_BIN -- requirements
Module: stoch_to_bin

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning output width in bits; the window length is W = 2^N enabled cycles.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port EN, input, 1 bit: sample enable; when low, IN is ignored and the window is frozen.
REQ-005 The block SHALL have port CLEAR, input, 1 bit: synchronous restart of the current window.
REQ-006 The block SHALL have port IN, input, 1 bit: unipolar stochastic bitstream, typically the product stream from the cascaded-AND multiplier.
REQ-007 The block SHALL have port OUT, output, N bits: binary estimate of the stream probability, as ones-count per window.
REQ-008 The block SHALL have port VALID, output, 1 bit: high while OUT holds an unacknowledged result.
REQ-009 The block SHALL have port ACK, input, 1 bit: consumer acknowledge, meaningful only while VALID=1.
REQ-010 The block SHALL have port OVR, output, 1 bit: sticky overrun flag.

Function
REQ-011 The block SHALL keep an internal (N+1)-bit ones counter and an N-bit window position counter.
REQ-012 The block SHALL, on each edge with EN=1 and CLEAR=0, increment the position counter and add IN to the ones counter.
REQ-013 The block SHALL, on each edge with EN=0 and CLEAR=0, hold both counters unchanged regardless of IN.
REQ-014 The block SHALL, on any edge with CLEAR=1, zero both counters, discard the partial window, and leave OUT, VALID and OVR unchanged; CLEAR has priority over EN.
REQ-015 The block SHALL treat the edge that samples the W-th enabled bit as window completion: that bit is counted, OUT is loaded with the final count, and VALID is set at that same edge (result visible one cycle after the last bit is presented).
REQ-016 The block SHALL, at window completion, zero both counters so that the next enabled edge begins a new window with no dead cycles.
REQ-017 The block SHALL saturate the loaded result: a count of 2^N loads OUT = 2^N-1; any other count loads unchanged.
REQ-018 The block SHALL hold OUT stable between window completions.
REQ-019 The block SHALL clear VALID on the edge where ACK=1 and VALID=1 and no window completes; ACK while VALID=0 has no effect.
REQ-020 The block SHALL, on an edge with window completion and VALID=1 and ACK=0, load the new OUT, keep VALID=1, and set OVR=1.
REQ-021 The block SHALL, on an edge with window completion and ACK=1, load the new OUT, keep VALID=1, and leave OVR unchanged.
REQ-022 The block SHALL keep OVR set until RESET.

Reset
REQ-023 The block SHALL, while RESET=1 and independent of CLK, force OUT=0, VALID=0, OVR=0, and both counters to 0.
REQ-024 The block SHALL, after RESET deasserts, start a fresh window on the first enabled edge.

Verification
REQ-025 The bench SHALL cover: N=4, IN=1 constant, EN=1 for 16 edges -> VALID=1, OUT=15 (saturated), OVR=0.
REQ-026 The bench SHALL cover: N=4, IN alternating 1,0 over 16 enabled edges -> OUT=8; IN=0 constant -> OUT=0 with VALID=1.
REQ-027 The bench SHALL cover: N=4, IN=1, EN low for 5 edges mid-window -> VALID rises only after the 21st edge, OUT=15.
REQ-028 The bench SHALL cover: N=4, no ACK across two windows (first 4 ones, second 12 ones) -> OUT=12, VALID=1, OVR=1; a later ACK clears VALID only.
REQ-029 The bench SHALL cover: ACK coincident with a window-completion edge -> VALID stays 1, OUT updates, OVR stays 0.
REQ-030 The bench SHALL cover: RESET asserted asynchronously at mid-window position 7, and separately CLEAR at position 7 -> after RESET all outputs are 0 immediately; after CLEAR OUT/VALID are kept; in both cases the next result needs 16 further enabled edges.
